// File: rtl/stream_burst_reader.sv
// ============================================================================
// stream_burst_reader: pops fixed-length bursts from an upstream FIFO into a
// registered downstream stream. Option macro: BURST_FLUSH_EN (idle flush).
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_burst_reader #(
  parameter int WIDTH        = 32,
  parameter int BURST_LEN    = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic [15:0]      occupied_i,
  output logic             burst_req_o,
  input  logic             burst_grant_i,
  output logic [8:0]       burst_len_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic             busy_o
);

  localparam logic [15:0] BURST_LEN16 = 16'(BURST_LEN);
  localparam logic [8:0]  BURST_LEN9  = 9'(BURST_LEN);

  generate
    if (BURST_LEN < 1 || BURST_LEN > 256 || FLUSH_CYCLES < 1) begin : g_param_check
      $error("stream_burst_reader: BURST_LEN must be 1..256 and FLUSH_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q;
  logic [8:0]       acc_q;
  logic [WIDTH-1:0] mdata_q;
  logic             mvalid_q;
  logic             mlast_q;
  logic [8:0]       len;
  logic             load;
  logic             last_word;

`ifdef BURST_FLUSH_EN
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  logic [8:0]         len_q;
  logic [FLUSH_W-1:0] flush_q;

  assign len = len_q;
`else
  assign len = BURST_LEN9;
`endif

  // Output register may reload only when empty or being drained this cycle.
  assign s_tready_o  = (state_q == ST_XFER) && (acc_q < len) && (m_tready_i || !mvalid_q);
  assign load        = s_tvalid_i && s_tready_o;
  assign last_word   = (acc_q == (len - 9'd1));
  assign burst_req_o = (state_q == ST_REQ);
  assign busy_o      = (state_q != ST_IDLE);
  assign burst_len_o = len;
  assign m_tdata_o   = mdata_q;
  assign m_tvalid_o  = mvalid_q;
  assign m_tlast_o   = mlast_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= 9'd0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
`ifdef BURST_FLUSH_EN
      len_q    <= BURST_LEN9;
      flush_q  <= '0;
`endif
    end else begin
      if (load) begin
        mdata_q  <= s_tdata_i;
        mvalid_q <= 1'b1;
        mlast_q  <= last_word;
        acc_q    <= acc_q + 9'd1;
      end else if (m_tready_i) begin
        mvalid_q <= 1'b0;
        mlast_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (occupied_i >= BURST_LEN16) begin
            state_q <= ST_REQ;
`ifdef BURST_FLUSH_EN
            len_q   <= BURST_LEN9;
            flush_q <= '0;
          end else if (occupied_i != 16'd0) begin
            // A partial FIFO that sits long enough is flushed as a short burst.
            if (flush_q == FLUSH_LAST) begin
              state_q <= ST_REQ;
              len_q   <= occupied_i[8:0];
              flush_q <= '0;
            end else begin
              flush_q <= flush_q + 1'b1;
            end
          end else begin
            flush_q <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (burst_grant_i) begin
            state_q <= ST_XFER;
            acc_q   <= 9'd0;
          end
        end
        ST_XFER: begin
          if (load && last_word) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mvalid_q && m_tready_i && mlast_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_burst_reader.sv
// ============================================================================
// tb_stream_burst_reader: scoreboard bench for stream_burst_reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_burst_reader;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [15:0]      occupied = 16'd0;
  logic             burst_req;
  logic             burst_grant = 1'b0;
  logic [8:0]       burst_len;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic             busy;

  stream_burst_reader #(.WIDTH(WIDTH), .BURST_LEN(16), .FLUSH_CYCLES(64)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .clear_i      (clear),
    .s_tdata_i    (s_tdata),
    .s_tvalid_i   (s_tvalid),
    .s_tready_o   (s_tready),
    .occupied_i   (occupied),
    .burst_req_o  (burst_req),
    .burst_grant_i(burst_grant),
    .burst_len_o  (burst_len),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .m_tlast_o    (m_tlast),
    .busy_o       (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          beat = 0;
  int          cur_len = 16;
  logic [31:0] base = '0;
  logic        hs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream handshake and checks
  // that a stalled output holds still.
  logic             pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
  logic [WIDTH-1:0] pd = '0;
  always @(negedge clock) begin
    exp_t e;
    if (!prst && pv && !pr) begin
      check("hold_valid", 64'(m_tvalid), 64'(1'b1));
      check("hold_data", 64'(m_tdata), 64'(pd));
      check("hold_last", 64'(m_tlast), 64'(pl));
    end
    if (m_tvalid && m_tready && !reset && !clear) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got 0x%0h, want none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", 64'(m_tdata), 64'(e.d));
        check("m_tlast", 64'(m_tlast), 64'(e.l));
      end
    end
    pv   = m_tvalid;
    pr   = m_tready;
    pd   = m_tdata;
    pl   = m_tlast;
    prst = reset | clear;
  end

  // One clock: sample the upstream handshake mid-cycle, then push the
  // accepted word's expected downstream appearance.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    hs = s_tvalid && s_tready;
    @(posedge clock);
    #1;
    if (hs) begin
      e.d = base + 32'(beat);
      e.l = (beat == cur_len - 1);
      exp_q.push_back(e);
      beat++;
      s_tdata = base + 32'(beat);
    end
  endtask

  task automatic start_burst(input int exp_len);
    int reqn;
    for (int k = 0; k < 200 && !burst_req; k++) cycle();
    check("req_seen", 64'(burst_req), 64'(1'b1));
    check("burst_len", 64'(burst_len), 64'(exp_len));
    reqn = 1;
    cycle();
    reqn += int'(burst_req);
    burst_grant = 1'b1;
    cycle();
    burst_grant = 1'b0;
    check("req_span", 64'(reqn), 64'(2));
    check("xfer_after_grant", 64'({busy, burst_req}), 64'(2'b10));
  endtask

  task automatic stream(input int len, input int mode, input int stall_at, input int stall_n,
                        input int clear_at, input logic [31:0] b);
    int stalled = 0;
    bit stall_checked = 1'b0;
    cur_len = len;
    beat    = 0;
    base    = b;
    s_tdata = b;
    for (int n = 0; n < 600; n++) begin
      m_tready = (mode == 1) ? (n % 2 == 0) : 1'b1;
      if (clear_at >= 0 && beat == clear_at) begin
        s_tvalid = 1'b0;
        clear    = 1'b1;
        cycle();
        clear    = 1'b0;
        m_tready = 1'b1;
        check("clr_busy", 64'(busy), 64'(1'b0));
        check("clr_m_tvalid", 64'(m_tvalid), 64'(1'b0));
        check("clr_m_tlast", 64'(m_tlast), 64'(1'b0));
        check("clr_burst_req", 64'(burst_req), 64'(1'b0));
        exp_q.delete();
        return;
      end
      if (beat == stall_at && stalled < stall_n) begin
        s_tvalid = 1'b0;
        stalled++;
      end else begin
        s_tvalid = (beat < len);
      end
      cycle();
      if (stall_n > 0 && stalled == stall_n && !stall_checked) begin
        stall_checked = 1'b1;
        check("stall_in_xfer", 64'({busy, s_tready, m_tvalid}), 64'(3'b110));
        check("stall_beat", 64'(beat), 64'(stall_at));
      end
      if (!busy) break;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    check("burst_done_idle", 64'(busy), 64'(1'b0));
    check("burst_words", 64'(beat), 64'(len));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int k;
    repeat (3) cycle();
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_outs", 64'({burst_req, m_tvalid, m_tlast, s_tready}), 64'(4'b0000));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_burst_len", 64'(burst_len), 64'(16));
    reset = 1'b0;

    // Threshold: 15 words is not enough, 16 starts a burst.
    occupied = 16'd15;
    repeat (5) cycle();
    check("no_req_at_15", 64'(burst_req), 64'(1'b0));
    occupied = 16'd16;
    cycle();
    check("req_at_16", 64'(burst_req), 64'(1'b1));
    occupied = 16'd0;
    start_burst(16);
    stream(16, 0, -1, 0, -1, 32'h1000_0000);

    // Downstream backpressure toggling every clock.
    occupied = 16'd16;
    cycle();
    occupied = 16'd0;
    start_burst(16);
    stream(16, 1, -1, 0, -1, 32'h2000_0000);

    // Upstream gap of 5 clocks after word 7.
    occupied = 16'd20;
    cycle();
    occupied = 16'd0;
    start_burst(16);
    stream(16, 0, 7, 5, -1, 32'h3000_0000);

    // Soft clear after word 9, then a fresh full burst.
    occupied = 16'd16;
    cycle();
    occupied = 16'd0;
    start_burst(16);
    stream(16, 0, -1, 0, 9, 32'h4000_0000);
    occupied = 16'd16;
    start_burst(16);
    occupied = 16'd0;
    stream(16, 0, -1, 0, -1, 32'h5000_0000);

    // Steady occupancy of 40: back-to-back bursts.
    occupied = 16'd40;
    start_burst(16);
    stream(16, 0, -1, 0, -1, 32'h6000_0000);
    cycle();
    check("b2b_req", 64'(burst_req), 64'(1'b1));
    start_burst(16);
    occupied = 16'd0;
    stream(16, 0, -1, 0, -1, 32'h7000_0000);

    // Partial occupancy held: flush timeout only with the option built.
    occupied = 16'd5;
    for (k = 1; k <= 100; k++) begin
      cycle();
      if (burst_req) break;
    end
`ifdef BURST_FLUSH_EN
    check("flush_delay", 64'(k), 64'(64));
    occupied = 16'd0;
    start_burst(5);
    stream(5, 0, -1, 0, -1, 32'h8000_0000);
`else
    check("no_flush_req", 64'(burst_req), 64'(1'b0));
    check("no_flush_busy", 64'(busy), 64'(1'b0));
    check("no_flush_len", 64'(burst_len), 64'(16));
    occupied = 16'd0;
`endif

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/stream_burst_reader.md
STREAM_BURST_READER -- requirements
Module: stream_burst_reader

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits.
REQ-002 Parameter BURST_LEN, default 16: full burst length in words, legal range 1..256.
REQ-003 Parameter FLUSH_CYCLES, default 64: idle-timeout threshold in clocks; used only when the macro in REQ-028 is defined.
REQ-004 Port clock, input, 1: sole clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port clear, input, 1: synchronous soft clear, same effect as reset.
REQ-007 Ports s_tdata/s_tvalid/s_tready, WIDTH/1/1, in/in/out: upstream FIFO read stream.
REQ-008 Port occupied, input, 16: upstream FIFO word count, unsigned.
REQ-009 Ports burst_req/burst_grant, 1/1, out/in: burst arbitration handshake.
REQ-010 Port burst_len, output, 9: length of the current burst in words.
REQ-011 Ports m_tdata/m_tvalid/m_tready/m_tlast, WIDTH/1/1/1, out/out/in/out: registered downstream stream.
REQ-012 Port busy, output, 1: high in every state except IDLE.

Function
REQ-013 States: IDLE, REQ, XFER, DRAIN.
REQ-014 In IDLE, if occupied >= BURST_LEN (16-bit unsigned compare), the block shall latch burst_len = BURST_LEN and enter REQ on the next clock.
REQ-015 burst_req shall be high exactly while in REQ.
REQ-016 burst_grant high in REQ shall move the state to XFER on the next clock and zero the accept counter; burst_grant in any other state is ignored.
REQ-017 In XFER, s_tready = (accept count < burst_len) & (m_tready | ~m_tvalid); s_tready shall be 0 in all other states.
REQ-018 Each s_tvalid & s_tready cycle shall load s_tdata into m_tdata and set m_tvalid on the next clock (1-cycle latency), then increment the accept counter.
REQ-019 m_tlast shall be set with the word accepted when accept count == burst_len-1; it is 0 for every other word.
REQ-020 When the output register is not reloaded and m_tready=1, m_tvalid shall clear.
REQ-021 m_tdata, m_tvalid and m_tlast shall hold stable while m_tvalid & ~m_tready.
REQ-022 Once the last word is accepted, the state shall move to DRAIN.
REQ-023 In DRAIN, the state shall move to IDLE on the clock where m_tvalid & m_tready & m_tlast.
REQ-024 If s_tvalid drops mid-burst, XFER shall stall indefinitely with no timeout and no word loss.
REQ-025 Back-to-back bursts are allowed: IDLE re-evaluates occupied on the cycle after leaving DRAIN.
REQ-026 clear or reset mid-burst shall abandon the burst. The next clock shall show IDLE, m_tvalid=0, m_tlast=0, burst_req=0, counters=0; words already popped are discarded.

Reset
REQ-027 On reset, the block shall enter IDLE and drive s_tready, burst_req, m_tvalid, m_tlast, busy and m_tdata to 0, with burst_len = BURST_LEN.

Configuration
REQ-028 Macro BURST_FLUSH_EN defined: in IDLE, a timeout counter shall increment each clock while 0 < occupied < BURST_LEN, and reset to 0 otherwise or on leaving IDLE.
REQ-029 With BURST_FLUSH_EN defined, when the counter reaches FLUSH_CYCLES-1, the block shall latch burst_len = occupied[8:0] and enter REQ; the short burst shall behave per REQ-016..REQ-023.
REQ-030 Macro undefined: no timeout counter is built, only full BURST_LEN bursts are issued, and burst_len is constant BURST_LEN.

Verification
REQ-031 BURST_LEN=16; occupied 15->16; grant 2 clocks after burst_req -> burst_req spans exactly 2 clocks; 16 words with m_tlast on the 16th only; IDLE after the last handshake.
REQ-032 m_tready toggling 1/0 each clock during XFER -> no word dropped or duplicated; outputs stable while stalled; data order preserved.
REQ-033 s_tvalid low for 5 clocks after word 7 -> block stalls in XFER; resumes with word 8; m_tlast still on word 16.
REQ-034 clear asserted after word 9 -> next clock: IDLE, m_tvalid=0, burst_req=0; a new burst starts from occupied >= 16.
REQ-035 BURST_FLUSH_EN, FLUSH_CYCLES=64, occupied held at 5 -> burst_req asserted after 64 IDLE clocks; burst_len=5; m_tlast on word 5. Without the macro -> no burst_req.
REQ-036 occupied=40 held steady -> two consecutive 16-word bursts with no gap beyond DRAIN->IDLE->REQ.
